ciop_iob_intr_sched: RTL and testbench
======================================

// Module: ciop_iob_intr_sched
// PURPOSE
//  Round-robin scheduler for the off-chip IOB interrupt path. Shares one
//  2-flit NoC output port among NUM_REQ interrupt requesters. Per accepted
//  request it builds the MSG_TYPE_INTERRUPT header flit and the payload
//  flit, then streams both flits out over a val/rdy handshake.
//  Sits between the interrupt sources and the IOB NoC output channel.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..16)
//  PTR_W      2   clog2(NUM_REQ), round-robin pointer width
//  CNT_W      16  width of the sent-packet counter
// PORTS
//  clk           in   1                 clock
//  rst_n         in   1                 async active-low reset
//  req_val       in   NUM_REQ           request valid, one per source
//  req_rdy       out  NUM_REQ           request accepted (one-hot or 0)
//  req_x         in   NUM_REQ*NOC_X_WIDTH  destination X, source i at slice i
//  req_y         in   NUM_REQ*NOC_Y_WIDTH  destination Y
//  req_data      in   NUM_REQ*64        raw payload flit
//  noc_out_val   out  1                 flit valid
//  noc_out_rdy   in   1                 downstream ready
//  noc_out_data  out  NOC_DATA_WIDTH    flit
//  busy          out  1                 packet in flight (state != IDLE)
//  pkt_count     out  CNT_W             completed packets, wraps
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, pkt_count=0, noc_out_val=0, noc_out_data=0,
//   req_rdy=0, busy=0. Reset is async. If reset asserts mid-packet, the
//   partial packet is dropped and no further flits are sent.
//  Arbitration (combinational): the winner is the first asserted req_val
//   found scanning from rr_ptr upward, wrapping modulo NUM_REQ.
//  Accept window: A = (state==IDLE) | (state==BODY & noc_out_rdy).
//   req_rdy[winner] = A & |req_val. Other bits are 0.
//  On accept (cycle T): latch winner x/y/data. rr_ptr <= winner+1 (mod
//   NUM_REQ). state <= HDR. The header is valid on noc_out at T+1.
//  Header flit: all bits 0 except:
//   - MSG_DST_X = x, MSG_DST_Y = y
//   - fbits = NOC_FBITS_L1
//   - length = 8'd1
//   - type = MSG_TYPE_INTERRUPT
//  Body flit: {data[63:16], 7'b0, data[8:0]}.
//  FSM:
//   IDLE: val=0. Go to HDR on accept.
//   HDR:  val=1, data=header. On rdy go to BODY.
//   BODY: val=1, data=body. On rdy: pkt_count++. Next state is HDR if a
//    new accept occurs in the same cycle (back-to-back, no bubble),
//    otherwise IDLE.
//  noc_out_val/noc_out_data are registered. They hold stable while
//   val & !rdy. val never drops without a handshake.
//  No request is accepted during HDR, or during BODY without rdy.
//  Requesters hold req_val and payload until req_rdy.
//  pkt_count wraps from 2^CNT_W-1 to 0.
// TESTING
//  1 Single req: req_val=4'b0100, x=3, y=5, data=64'hDEAD_BEEF_0000_01FF, rdy=1
//    -> req_rdy=4'b0100 in one cycle.
//    -> next cycle: header with DST_X=3, DST_Y=5, MSG_TYPE_INTERRUPT.
//    -> then body 64'hDEAD_BEEF_0000_01FF & ~64'hFE00.
//    -> pkt_count=1.
//  2 All 4 requesting continuously, rdy=1 -> grants 0,1,2,3,0.
//    -> 8 flits back-to-back with no idle cycle.
//  3 Backpressure: rdy=0 for 5 cycles during HDR
//    -> header held stable, no req_rdy.
//    -> after rdy returns, body follows in 1 cycle.
//  4 Reset asserted in BODY -> same cycle val=0, state=IDLE, pkt_count=0.
//    -> after release, rr_ptr=0 and source 0 wins a tie.
//  5 pkt_count preloaded (force) to 16'hFFFF, one packet -> pkt_count=0.
//  6 Req from source 3 only, rr_ptr=1 -> source 3 granted.
//    -> rr_ptr wraps to 0.

Source files
------------

// File: rtl/ciop_iob_intr_sched.sv
// Round-robin interrupt scheduler for the IOB NoC output port.
// Grants one requester at a time and streams its header and body flits.
module ciop_iob_intr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int PTR_W          = 2,
  parameter int CNT_W          = 16,
  parameter int NOC_X_WIDTH    = 8,
  parameter int NOC_Y_WIDTH    = 8,
  parameter int NOC_DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_val,
  output logic [NUM_REQ-1:0]              req_rdy,
  input  logic [NUM_REQ*NOC_X_WIDTH-1:0]  req_x,
  input  logic [NUM_REQ*NOC_Y_WIDTH-1:0]  req_y,
  input  logic [NUM_REQ*64-1:0]           req_data,
  output logic                            noc_out_val,
  input  logic                            noc_out_rdy,
  output logic [NOC_DATA_WIDTH-1:0]       noc_out_data,
  output logic                            busy,
  output logic [CNT_W-1:0]                pkt_count
);

  localparam int DSTX_LO  = 42;
  localparam int DSTY_LO  = 34;
  localparam int FBITS_LO = 30;
  localparam int LEN_LO   = 22;
  localparam int TYPE_LO  = 14;

  localparam logic [3:0] NOC_FBITS_L1       = 4'b0000;
  localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'd33;
  localparam logic [7:0] MSG_LEN_ONE        = 8'd1;

  localparam logic [PTR_W:0] NREQ = NUM_REQ[PTR_W:0];
  localparam logic [63:0] BODY_MASK = 64'h0000_0000_0000_FE00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_e;

  state_e                    state_q;
  logic [PTR_W-1:0]          rr_ptr_q;
  logic [63:0]               body_q;
  logic                      val_q;
  logic [NOC_DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      win_found;
  logic [PTR_W-1:0]          win_idx;
  logic [PTR_W:0]            scan_idx;
  logic [PTR_W:0]            nxt_ext;
  logic [PTR_W-1:0]          nxt_ptr;
  logic                      acc_win;
  logic                      acc;
  logic [NOC_X_WIDTH-1:0]    win_x;
  logic [NOC_Y_WIDTH-1:0]    win_y;
  logic [63:0]               win_data;
  logic [NOC_DATA_WIDTH-1:0] hdr_w;

  // First asserted request at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + i[PTR_W:0];
      if (scan_idx >= NREQ)
        scan_idx = scan_idx - NREQ;
      if (!win_found && req_val[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    nxt_ext = {1'b0, win_idx} + {{PTR_W{1'b0}}, 1'b1};
    if (nxt_ext >= NREQ)
      nxt_ext = '0;
    nxt_ptr = nxt_ext[PTR_W-1:0];
  end

  assign acc_win = (state_q == S_IDLE) |
                   ((state_q == S_BODY) & noc_out_rdy);
  assign acc     = acc_win & win_found;

  always_comb begin
    req_rdy          = '0;
    req_rdy[win_idx] = acc;
  end

  assign win_x    = req_x[win_idx*NOC_X_WIDTH +: NOC_X_WIDTH];
  assign win_y    = req_y[win_idx*NOC_Y_WIDTH +: NOC_Y_WIDTH];
  assign win_data = req_data[win_idx*64 +: 64];

  always_comb begin
    hdr_w                            = '0;
    hdr_w[DSTX_LO  +: NOC_X_WIDTH]   = win_x;
    hdr_w[DSTY_LO  +: NOC_Y_WIDTH]   = win_y;
    hdr_w[FBITS_LO +: 4]             = NOC_FBITS_L1;
    hdr_w[LEN_LO   +: 8]             = MSG_LEN_ONE;
    hdr_w[TYPE_LO  +: 8]             = MSG_TYPE_INTERRUPT;
  end

  // Header is built from the live winner so it appears the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      body_q   <= '0;
      val_q    <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (acc) begin
            state_q  <= S_HDR;
            val_q    <= 1'b1;
            data_q   <= hdr_w;
            body_q   <= win_data & ~BODY_MASK;
            rr_ptr_q <= nxt_ptr;
          end
        end
        S_HDR: begin
          if (noc_out_rdy) begin
            state_q <= S_BODY;
            data_q  <= body_q;
          end
        end
        S_BODY: begin
          if (noc_out_rdy) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (acc) begin
              state_q  <= S_HDR;
              data_q   <= hdr_w;
              body_q   <= win_data & ~BODY_MASK;
              rr_ptr_q <= nxt_ptr;
            end else begin
              state_q <= S_IDLE;
              val_q   <= 1'b0;
              data_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          val_q   <= 1'b0;
          data_q  <= '0;
        end
      endcase
    end
  end

  assign noc_out_val  = val_q;
  assign noc_out_data = data_q;
  assign busy         = (state_q != S_IDLE);
  assign pkt_count    = cnt_q;

endmodule

// File: tb/tb_ciop_iob_intr_sched.sv
// Bench for ciop_iob_intr_sched: directed scenarios plus random traffic
// checked against a flit-queue reference model.
module tb_ciop_iob_intr_sched;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_val;
  logic [3:0]    req_rdy;
  logic [31:0]   req_x;
  logic [31:0]   req_y;
  logic [255:0]  req_data;
  logic          noc_out_val;
  logic          noc_out_rdy;
  logic [63:0]   noc_out_data;
  logic          busy;
  logic [15:0]   pkt_count;

  ciop_iob_intr_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_data     (req_data),
    .noc_out_val  (noc_out_val),
    .noc_out_rdy  (noc_out_rdy),
    .noc_out_data (noc_out_data),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        pend [4];
  logic [7:0]  px   [4];
  logic [7:0]  py   [4];
  logic [63:0] pd   [4];

  logic [63:0] q[$];
  int          mptr;
  logic [15:0] mcnt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] x,
                                         input logic [7:0] y);
    logic [63:0] h;
    h = 64'd0;
    h = h | (64'(x) << 42);
    h = h | (64'(y) << 34);
    h = h | (64'd1 << 22);
    h = h | (64'd33 << 14);
    return h;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_val[i]            = pend[i];
      req_x[i*8 +: 8]       = px[i];
      req_y[i*8 +: 8]       = py[i];
      req_data[i*64 +: 64]  = pd[i];
    end
  endtask

  task automatic set_src(input int i, input logic [7:0] x,
                         input logic [7:0] y, input logic [63:0] d);
    pend[i] = 1'b1;
    px[i]   = x;
    py[i]   = y;
    pd[i]   = d;
  endtask

  task automatic model_reset();
    q.delete();
    mptr = 0;
    mcnt = 16'd0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      px[i]   = 8'd0;
      py[i]   = 8'd0;
      pd[i]   = 64'd0;
    end
  endtask

  // One cycle: drive at negedge, check 1ns later, advance the model.
  task automatic step(input logic rdy, input int pnew);
    logic       exp_val;
    logic       can;
    logic [3:0] exp_rdy;
    int         gi;
    int         idx;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!pend[i] && pnew > 0 && $urandom_range(0, 99) < pnew)
        set_src(i, 8'($urandom), 8'($urandom), {$urandom, $urandom});
    end
    noc_out_rdy = rdy;
    drive();
    #1;
    exp_val = (q.size() != 0);
    chk("val", 64'(noc_out_val), 64'(exp_val));
    if (exp_val)
      chk("data", noc_out_data, q[0]);
    chk("busy", 64'(busy), 64'(exp_val));
    chk("cnt", 64'(pkt_count), 64'(mcnt));
    can = (q.size() == 0) || (q.size() == 1 && rdy);
    gi = -1;
    exp_rdy = 4'b0;
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        idx = (mptr + k) % 4;
        if (gi < 0 && pend[idx])
          gi = idx;
      end
    end
    if (gi >= 0)
      exp_rdy[gi] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    if (exp_val && rdy) begin
      if (q.size() == 1)
        mcnt = mcnt + 16'd1;
      void'(q.pop_front());
    end
    if (gi >= 0) begin
      q.push_back(mk_hdr(px[gi], py[gi]));
      q.push_back(pd[gi] & ~64'hFE00);
      mptr = (gi + 1) % 4;
      pend[gi] = 1'b0;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 6; i++)
      step(1'b1, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    noc_out_rdy = 1'b0;
    req_val     = 4'b0;
    req_x       = '0;
    req_y       = '0;
    req_data    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_val", 64'(noc_out_val), 64'd0);
    chk("rst_data", noc_out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(pkt_count), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request from source 2
    set_src(2, 8'd3, 8'd5, 64'hDEAD_BEEF_0000_01FF);
    step(1'b1, 0);
    chk("t1_grant", 64'(req_rdy), 64'h4);
    step(1'b1, 0);
    chk("t1_hdr", noc_out_data, mk_hdr(8'd3, 8'd5));
    step(1'b1, 0);
    chk("t1_body", noc_out_data, 64'hDEAD_BEEF_0000_0000 | 64'h1FF);
    step(1'b1, 0);
    chk("t1_cnt", 64'(pkt_count), 64'd1);

    // all four requesting, full throughput
    for (int i = 0; i < 10; i++)
      step(1'b1, 100);
    flush();

    // backpressure while header is presented
    set_src(1, 8'h11, 8'h22, 64'h0123_4567_89AB_CDEF);
    step(1'b1, 0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 0);
    flush();

    // rr_ptr to 1, then only source 3 requests
    set_src(0, 8'h01, 8'h02, 64'h1);
    flush();
    set_src(3, 8'h33, 8'h44, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 0);
    chk("t6_grant", 64'(req_rdy), 64'h8);
    flush();
    set_src(0, 8'h05, 8'h06, 64'h2);
    set_src(1, 8'h07, 8'h08, 64'h3);
    step(1'b1, 0);
    chk("t6_wrap", 64'(req_rdy), 64'h1);
    flush();

    // counter wrap
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    mcnt = 16'hFFFF;
    set_src(2, 8'h09, 8'h0A, 64'h55);
    flush();
    chk("t5_wrap", 64'(pkt_count), 64'd0);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 30);
    flush();

    // reset in BODY
    set_src(2, 8'h0C, 8'h0D, 64'hABCD);
    step(1'b1, 0);
    step(1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_val", 64'(noc_out_val), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_cnt", 64'(pkt_count), 64'd0);
    model_reset();
    noc_out_rdy = 1'b1;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      set_src(i, 8'(i), 8'(i + 4), 64'(i));
    step(1'b1, 0);
    chk("t4_tie", 64'(req_rdy), 64'h1);
    for (int i = 0; i < 12; i++)
      step(1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
